// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 at a 25.2 MHz pixel rate.
package vga_timing_pkg;

  localparam int unsigned POS_W     = 10;
  localparam int unsigned MAX_TOTAL = 1024;

  localparam int unsigned DEF_H_DISPLAY  = 640;
  localparam int unsigned DEF_H_FRONT    = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BACK     = 48;
  localparam int unsigned DEF_V_DISPLAY  = 480;
  localparam int unsigned DEF_V_FRONT    = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BACK     = 33;
  localparam int unsigned DEF_FRAME_BITS = 9;

  function automatic int unsigned h_total(input int unsigned display, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return display + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned display, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel-colour stage.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS
);
  logic                  ce;
  logic [POS_W-1:0]      hpos;
  logic [POS_W-1:0]      vpos;
  logic                  hsync;
  logic                  vsync;
  logic                  display_on;
  logic                  line_start;
  logic                  frame_start;
  logic [FRAME_BITS-1:0] frame_no;

  modport master (
    input  ce,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_no
  );

  modport slave (
    output ce,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_no
  );
endinterface

// File: rtl/raster_axis_counter.sv
// One raster axis: position counter with registered sync/active flags that
// always match the registered position.
module raster_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_END   = 752,
  parameter int unsigned ACTIVE_END = 640
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             sync_active,
  output logic             active
);

  localparam int unsigned      W1          = POS_W + 1;
  localparam logic [POS_W-1:0] LAST        = POS_W'(TOTAL - 1);
  localparam logic             SYNC_AT_0   = (SYNC_START == 0) && (SYNC_END > 0);
  localparam logic             ACTIVE_AT_0 = (ACTIVE_END > 0);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             sync_q, sync_d;
  logic             active_q, active_d;

  // Flags are derived from the next position so they land on the same edge as pos.
  always_comb begin
    wrap     = advance && (pos_q == LAST);
    pos_d    = pos_q;
    if (advance) begin
      pos_d = wrap ? '0 : pos_q + POS_W'(1);
    end
    sync_d   = ({1'b0, pos_d} >= W1'(SYNC_START)) && ({1'b0, pos_d} < W1'(SYNC_END));
    active_d = {1'b0, pos_d} < W1'(ACTIVE_END);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q    <= '0;
      sync_q   <= SYNC_AT_0;
      active_q <= ACTIVE_AT_0;
    end else begin
      pos_q    <= pos_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign pos         = pos_q;
  assign sync_active = sync_q;
  assign active      = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, sync polarity, line/frame strobes and a
// completed-frame counter, all advancing on the pixel clock enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_DISPLAY  = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vif
);

  localparam int unsigned H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds 10-bit counter range");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds 10-bit counter range");
  end

  logic                  h_wrap, h_sync_act, h_active;
  logic                  v_wrap, v_sync_act, v_active;
  logic                  line_start_q, frame_start_q;
  logic [FRAME_BITS-1:0] frame_no_q;

  raster_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC),
    .ACTIVE_END (H_DISPLAY)
  ) u_h_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (vif.ce),
    .pos         (vif.hpos),
    .wrap        (h_wrap),
    .sync_active (h_sync_act),
    .active      (h_active)
  );

  // h_wrap already carries ce, so the vertical axis steps once per completed line.
  raster_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_DISPLAY + V_FRONT),
    .SYNC_END   (V_DISPLAY + V_FRONT + V_SYNC),
    .ACTIVE_END (V_DISPLAY)
  ) u_v_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (h_wrap),
    .pos         (vif.vpos),
    .wrap        (v_wrap),
    .sync_active (v_sync_act),
    .active      (v_active)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_no_q    <= '0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      frame_no_q    <= frame_no_q + FRAME_BITS'(v_wrap);
    end
  end

  assign vif.hsync       = h_sync_act ? H_SYNC_POL : ~H_SYNC_POL;
  assign vif.vsync       = v_sync_act ? V_SYNC_POL : ~V_SYNC_POL;
  assign vif.display_on  = h_active & v_active;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_no    = frame_no_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance for line timing and ce gating, plus a tiny
// raster (7x5 totals, 2-bit frame counter) for frame, wrap and reset cases.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, rst_s;

  vga_timing_gen_if #(.FRAME_BITS(9)) big_if ();
  vga_timing_gen_if #(.FRAME_BITS(2)) sm_if ();

  vga_timing_gen u_big (
    .clk   (clk),
    .rst_n (rst_b),
    .vif   (big_if)
  );

  vga_timing_gen #(
    .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
    .V_DISPLAY (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .FRAME_BITS(2)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_s),
    .vif   (sm_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned adv;
    int unsigned hpos, vpos, hsync, de, ls;
  } vec_t;
  vec_t vecs[10];

  // Small-raster reference model state.
  int unsigned m_h, m_v, m_f, e_ls, e_fs;
  int unsigned fno_log[$];

  task automatic small_run(input int n, input bit toggle);
    for (int k = 0; k < n; k++) begin
      sm_if.ce = toggle ? ((k % 2) == 0) : 1'b1;
      tick();
      e_ls = 0;
      e_fs = 0;
      if (sm_if.ce) begin
        if (m_h == 6) begin
          m_h  = 0;
          e_ls = 1;
          if (m_v == 4) begin
            m_v  = 0;
            m_f  = (m_f + 1) % 4;
            e_fs = 1;
          end else begin
            m_v++;
          end
        end else begin
          m_h++;
        end
      end
      check("sm_hpos", sm_if.hpos, m_h);
      check("sm_vpos", sm_if.vpos, m_v);
      check("sm_hsync", sm_if.hsync, (m_h == 5) ? 0 : 1);
      check("sm_vsync", sm_if.vsync, (m_v == 3) ? 0 : 1);
      check("sm_display_on", sm_if.display_on, (m_h < 4 && m_v < 2) ? 1 : 0);
      check("sm_line_start", sm_if.line_start, e_ls);
      check("sm_frame_start", sm_if.frame_start, e_fs);
      check("sm_frame_no", sm_if.frame_no, m_f);
      if (sm_if.frame_start) fno_log.push_back(sm_if.frame_no);
    end
  endtask

  initial begin
    int unsigned prev_h, prev_v, prev_hs, prev_vs, prev_de, prev_f;
    int hold_err, skew_err, ls_cnt, ls_first, ls_last, fs_wait;
    bit ce_now;

    vecs[0] = '{adv: 639, hpos: 639, vpos: 0, hsync: 1, de: 1, ls: 0};
    vecs[1] = '{adv: 1,   hpos: 640, vpos: 0, hsync: 1, de: 0, ls: 0};
    vecs[2] = '{adv: 15,  hpos: 655, vpos: 0, hsync: 1, de: 0, ls: 0};
    vecs[3] = '{adv: 1,   hpos: 656, vpos: 0, hsync: 0, de: 0, ls: 0};
    vecs[4] = '{adv: 95,  hpos: 751, vpos: 0, hsync: 0, de: 0, ls: 0};
    vecs[5] = '{adv: 1,   hpos: 752, vpos: 0, hsync: 1, de: 0, ls: 0};
    vecs[6] = '{adv: 47,  hpos: 799, vpos: 0, hsync: 1, de: 0, ls: 0};
    vecs[7] = '{adv: 1,   hpos: 0,   vpos: 1, hsync: 1, de: 1, ls: 1};
    vecs[8] = '{adv: 1,   hpos: 1,   vpos: 1, hsync: 1, de: 1, ls: 0};
    vecs[9] = '{adv: 799, hpos: 0,   vpos: 2, hsync: 1, de: 1, ls: 1};

    rst_b = 1'b0;
    rst_s = 1'b0;
    big_if.ce = 1'b1;
    sm_if.ce  = 1'b1;
    repeat (3) tick();
    check("rst_hpos", big_if.hpos, 0);
    check("rst_vpos", big_if.vpos, 0);
    check("rst_hsync", big_if.hsync, 1);
    check("rst_vsync", big_if.vsync, 1);
    check("rst_display_on", big_if.display_on, 1);
    check("rst_line_start", big_if.line_start, 0);
    check("rst_frame_start", big_if.frame_start, 0);
    check("rst_frame_no", big_if.frame_no, 0);
    rst_b = 1'b1;

    for (int i = 0; i < 10; i++) begin
      repeat (vecs[i].adv) tick();
      check("line_hpos", big_if.hpos, vecs[i].hpos);
      check("line_vpos", big_if.vpos, vecs[i].vpos);
      check("line_hsync", big_if.hsync, vecs[i].hsync);
      check("line_display_on", big_if.display_on, vecs[i].de);
      check("line_line_start", big_if.line_start, vecs[i].ls);
      check("line_vsync", big_if.vsync, 1);
    end

    // ce toggling 1,0,1,0 from hpos=0, vpos=2: a line now takes 1600 clks.
    hold_err = 0; skew_err = 0; ls_cnt = 0; ls_first = -1; ls_last = -1;
    for (int i = 0; i < 3300; i++) begin
      prev_h = big_if.hpos;  prev_v = big_if.vpos;
      prev_hs = big_if.hsync; prev_vs = big_if.vsync;
      prev_de = big_if.display_on; prev_f = big_if.frame_no;
      ce_now = ((i % 2) == 0);
      big_if.ce = ce_now;
      tick();
      if (!ce_now && (big_if.hpos != prev_h || big_if.vpos != prev_v || big_if.hsync != prev_hs ||
                      big_if.vsync != prev_vs || big_if.display_on != prev_de ||
                      big_if.frame_no != prev_f || big_if.line_start || big_if.frame_start))
        hold_err++;
      if (big_if.hsync != !(big_if.hpos >= 656 && big_if.hpos <= 751)) skew_err++;
      if (big_if.display_on != (big_if.hpos < 640 && big_if.vpos < 480)) skew_err++;
      if (big_if.line_start) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = i;
        ls_last = i;
      end
    end
    big_if.ce = 1'b1;
    check("ce_hold", hold_err, 0);
    check("ce_sync_skew", skew_err, 0);
    check("ce_line_start_count", ls_cnt, 2);
    check("ce_first_line_start", ls_first, 1598);
    check("ce_line_period", ls_last - ls_first, 1600);
    check("ce_vpos", big_if.vpos, 4);
    check("ce_frame_no", big_if.frame_no, 0);

    // Small raster: 7 clks per line, 35 clks per frame.
    repeat (3) tick();
    check("sm_rst_hpos", sm_if.hpos, 0);
    check("sm_rst_vpos", sm_if.vpos, 0);
    check("sm_rst_hsync", sm_if.hsync, 1);
    check("sm_rst_vsync", sm_if.vsync, 1);
    check("sm_rst_display_on", sm_if.display_on, 1);
    check("sm_rst_frame_no", sm_if.frame_no, 0);
    rst_s = 1'b1;
    m_h = 0; m_v = 0; m_f = 0;

    small_run(140, 1'b0);
    check("wrap_frame_count", fno_log.size(), 4);
    if (fno_log.size() == 4) begin
      check("wrap_fno0", fno_log[0], 1);
      check("wrap_fno1", fno_log[1], 2);
      check("wrap_fno2", fno_log[2], 3);
      check("wrap_fno3", fno_log[3], 0);
    end

    small_run(140, 1'b1);
    small_run(52, 1'b0);
    check("mid_vpos", sm_if.vpos, 2);
    check("mid_frame_no", sm_if.frame_no, 3);

    rst_s = 1'b0;
    tick();
    rst_s = 1'b1;
    check("mid_rst_hpos", sm_if.hpos, 0);
    check("mid_rst_vpos", sm_if.vpos, 0);
    check("mid_rst_frame_no", sm_if.frame_no, 0);
    check("mid_rst_line_start", sm_if.line_start, 0);
    check("mid_rst_frame_start", sm_if.frame_start, 0);
    check("mid_rst_vsync", sm_if.vsync, 1);

    fs_wait = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (sm_if.frame_start) begin
        fs_wait = n;
        break;
      end
    end
    check("mid_next_frame_start", fs_wait, 35);
    check("mid_next_frame_no", sm_if.frame_no, 1);
    check("mid_next_line_start", sm_if.line_start, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing for the video path: pixel and line counters, sync pulses, a display-active flag, line and frame strobes, and a frame counter. It sits directly upstream of the pixel-colour stage, which consumes hpos, vpos, display_on, hsync, vsync and frame_no. A clean synchronous frame counter and strobes replace any per-design counting on sync edges. The default configuration is 640x480@60 with a 25.2 MHz pixel rate, qualified by a clock enable.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level (0 = active-low)
FRAME_BITS, 9, frame counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
ce  in  1  pixel-clock enable; counters advance only when ce=1
hpos  out  10  current pixel column, 0..H_TOTAL-1
vpos  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync at H_SYNC_POL level
vsync  out  1  vertical sync at V_SYNC_POL level
display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
line_start  out  1  one-clk pulse when hpos becomes 0 by wrap
frame_start  out  1  one-clk pulse when (hpos,vpos) becomes (0,0) by wrap
frame_no  out  FRAME_BITS  completed-frame count, modulo 2^FRAME_BITS

Behaviour:
- Derived values: H_TOTAL = sum of the H_* widths (800); V_TOTAL = sum of the V_* widths (525).
- Reset, on the clk edge with rst_n=0: hpos=0, vpos=0, hsync=vsync=inactive level, display_on=1, line_start=0, frame_start=0, frame_no=0. Reset overrides ce. Reset mid-frame aborts the frame immediately. No strobe is issued for the reset-induced (0,0).
- All outputs are registered and updated on the same edge as the counters. hsync, vsync and display_on always correspond to the hpos/vpos values presented in the same cycle, with zero skew between them.
- On an edge with ce=1:
  - hpos increments; at H_TOTAL-1 it wraps to 0.
  - vpos increments only on an hpos wrap; at V_TOTAL-1 it wraps to 0.
  - frame_no increments on the vpos wrap and wraps naturally at 2^FRAME_BITS.
- On an edge with ce=0: counters, syncs, display_on and frame_no hold; line_start and frame_start are 0.
- line_start=1 for exactly the one clk following an hpos wrap. frame_start=1 only in that same clk when vpos also wrapped, and it then coincides with line_start and the new frame_no value.
- hsync is active for H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync is active for V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), over the full line width.
- Arithmetic: comparisons are unsigned, 10-bit. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; this is checked at elaboration.

Decomposition:
- Package vga_timing_pkg holds the 640x480@60 default constants plus H_TOTAL/V_TOTAL helper functions.
- Sub-module raster_axis_counter, instantiated twice (horizontal and vertical). Parameters: TOTAL, SYNC_START, SYNC_END, ACTIVE_END. Inputs: clk, rst_n, advance. Outputs: pos, wrap, sync_active, active.
- The top level handles polarity, strobes and frame_no.

Test Plan:
- Reset: hold rst_n=0 for 3 clks with ce=1 -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, strobes=0, frame_no=0.
- Line timing, ce=1 constantly after reset:
  - display_on falls when hpos=640.
  - hsync=0 exactly while hpos is 656..751.
  - hpos wraps after 799, with line_start=1 for 1 clk at hpos=0, vpos=1, every 800 clks.
- Frame timing:
  - vsync=0 for vpos 490..491 (1600 clks).
  - 420000 clks after reset: frame_start=1, line_start=1, frame_no=1, hpos=vpos=0.
- ce gating, ce toggling 1,0,1,0:
  - all periods double (line = 1600 clks).
  - line_start stays a single-clk pulse.
  - outputs hold on ce=0 clks.
- Reset mid-frame: assert rst_n=0 for 1 clk at vpos=300, frame_no=5 -> next cycle all reset values, frame_no=0. The next frame_start comes 420000 clks later.
- Wrap, using small parameters (H: 4,1,1,1; V: 2,1,1,1; FRAME_BITS=2) -> frame_no sequence 1,2,3,0 at 35-clk intervals, no missed or double strobe.
